clint_timer: RTL and testbench
==============================

Name: clint_timer

Overview:
- Memory-mapped machine timer: holds mtime and mtimecmp and raises the level timer interrupt consumed by the core-local interruptor.
- Sits between the data-memory bus (MMIO slave port) and the interrupt controller; its timer_int_o drives the controller's timer interrupt input.
- mtime advances once per PRESCALE clock cycles.

Parameters:
- BASE_ADDR, 64'h0000_0000_0200_0000, CLINT region base; only bits [63:16] are compared.
- PRESCALE, 1, clk cycles per mtime increment; legal range 1..65535.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- req_valid_i  input  1  bus request valid
- req_ready_o  output  1  slave can accept request
- req_wen_i  input  1  1 = write, 0 = read
- req_addr_i  input  64  byte address
- req_wdata_i  input  64  write data
- req_wstrb_i  input  8  byte write strobes
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  master accepts response
- rsp_rdata_o  output  64  read data
- rsp_err_o  output  1  access fault (unmapped or misaligned)
- timer_int_o  output  1  machine timer interrupt, level

Behaviour:
- Reset (async, rst=1):
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescale count=0, FSM=IDLE.
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, timer_int_o=0, req_ready_o=1.
- Register map (offsets from BASE_ADDR):
  - 0x4000 mtimecmp, RW.
  - 0xBFF8 mtime, RW.
  - Any other offset, addr[63:16] != BASE_ADDR[63:16], or addr[2:0] != 0 -> error.
- Prescaler:
  - Count runs 0..PRESCALE-1; tick is asserted in the cycle where count==PRESCALE-1, after which count wraps to 0.
  - With PRESCALE=1, tick is asserted every cycle.
  - On tick, mtime <= mtime+1, wrapping 64'hFFFF_FFFF_FFFF_FFFF -> 0.
- Bus FSM, two states:
  - IDLE: req_ready_o=1. On req_valid_i: decode, perform the write, latch response, go to RESP.
  - RESP: req_ready_o=0, rsp_valid_o=1. rsp_rdata_o and rsp_err_o are held stable until rsp_ready_i=1, then return to IDLE.
  - Latency: accept at cycle N -> rsp_valid_o at N+1. Maximum throughput is one request per 2 cycles.
- Reads:
  - Return the register value as of the accept cycle, i.e. before any tick in that cycle.
  - Errored reads return 0.
- Writes:
  - Byte-merged per req_wstrb_i; wstrb=0 writes nothing but still responds with no error.
  - rsp_rdata_o=0 on writes.
  - Errored writes modify nothing.
- Write to mtime in a tick cycle: the bus write wins and the increment is dropped for that cycle. The prescale count is unaffected.
- Interrupt:
  - timer_int_o is registered: timer_int_o <= (mtime >= mtimecmp), unsigned, evaluated on current register values every cycle.
  - One cycle of latency from any register change.
  - Level stays asserted until software raises mtimecmp or lowers mtime.
- Reset mid-transaction: the response is discarded, FSM returns to IDLE, and the master must reissue.

Optional Feature:
- Macro CLINT_MSIP_EN.
- When defined:
  - Adds register msip at offset 0x0000, RW. Only bit 0 is stored; other bits read 0. Reset 0; writes honour wstrb[0].
  - Adds output soft_int_o (1 bit), equal to the registered msip[0]; asserted one cycle after the write response is issued.
- When undefined: offset 0x0000 is an error and the soft_int_o port does not exist.

Test Plan:
- Reset then idle 10 cycles, PRESCALE=1 -> read mtime returns 10 ±1 (as sampled at accept); timer_int_o=0; rsp_err_o=0.
- Write mtimecmp=20, wstrb=8'hFF, with mtime=5 -> timer_int_o rises exactly 1 cycle after the cycle mtime becomes 20; write mtimecmp=64'hFFFF_FFFF_FFFF_FFFF -> timer_int_o falls 1 cycle later.
- PRESCALE=4 -> mtime increments once every 4 cycles; 40 cycles after reset, mtime=10.
- Write mtime=64'hFFFF_FFFF_FFFF_FFFE with mtimecmp=0 -> wraps to 0 after 2 ticks; timer_int_o stays 1 throughout.
- Read 0x0200_1000 and 0x0200_4004 -> rsp_err_o=1, rdata=0, no state change. Hold rsp_ready_i=0 for 3 cycles -> rsp_valid_o held and req_ready_o=0 for those cycles.
- Byte write to mtime with wstrb=8'h01, data 8'hAA, issued in a tick cycle -> mtime[7:0]=8'hAA, upper bytes unchanged, no increment that cycle. With CLINT_MSIP_EN: write msip=1 -> soft_int_o=1.

Source files
------------

// File: rtl/clint_timer.sv
// clint_timer: memory-mapped machine timer (mtime / mtimecmp) with a level timer interrupt.
// Optional machine software interrupt register (msip) and soft_int_o output when
// CLINT_MSIP_EN is defined.
`timescale 1ns/1ps
module clint_timer #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wen_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  input  logic [7:0]  req_wstrb_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        timer_int_o
`ifdef CLINT_MSIP_EN
  ,
  output logic        soft_int_o
`endif
);

  localparam int unsigned PW           = 16;
  localparam logic [PW-1:0] PS_LAST    = PW'(PRESCALE - 1);
  localparam logic [15:0] OFF_MTIMECMP = 16'h4000;
  localparam logic [15:0] OFF_MTIME    = 16'hBFF8;

  typedef enum logic {ST_IDLE, ST_RESP} state_t;

  state_t        state;
  logic [PW-1:0] ps_cnt;
  logic          tick;
  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;

  logic          accept;
  logic          sel_cmp;
  logic          sel_time;
  logic          sel_msip;
  logic          dec_err;
  logic          wr_cmp;
  logic          wr_time;
  logic [63:0]   rd_val;

`ifdef CLINT_MSIP_EN
  localparam logic [15:0] OFF_MSIP = 16'h0000;
  logic          msip_q;
  logic          wr_msip;
`endif

  // Byte-lane merge of write data into an existing register value.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    res = old_val;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  assign accept = (state == ST_IDLE) && req_valid_i;
  assign tick   = (ps_cnt == PS_LAST);

  // Address decode and read-data select for the request currently on the bus.
  always_comb begin
    sel_cmp  = 1'b0;
    sel_time = 1'b0;
    sel_msip = 1'b0;
    rd_val   = 64'd0;
    if ((req_addr_i[63:16] == BASE_ADDR[63:16]) && (req_addr_i[2:0] == 3'b000)) begin
      sel_cmp  = (req_addr_i[15:0] == OFF_MTIMECMP);
      sel_time = (req_addr_i[15:0] == OFF_MTIME);
`ifdef CLINT_MSIP_EN
      sel_msip = (req_addr_i[15:0] == OFF_MSIP);
`endif
    end
    if (sel_cmp)  rd_val = mtimecmp;
    if (sel_time) rd_val = mtime;
`ifdef CLINT_MSIP_EN
    if (sel_msip) rd_val = {63'd0, msip_q};
`endif
    dec_err = !(sel_cmp || sel_time || sel_msip);
  end

  assign wr_cmp  = accept && req_wen_i && sel_cmp;
  // A zero-strobe write leaves mtime alone, so it does not suppress the tick either.
  assign wr_time = accept && req_wen_i && sel_time && (|req_wstrb_i);

  // Prescaler: count 0..PRESCALE-1, tick on the last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ps_cnt <= '0;
    else if (tick) ps_cnt <= '0;
    else           ps_cnt <= ps_cnt + PW'(1);
  end

  // mtime: bus write takes priority over the tick increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          mtime <= 64'd0;
    else if (wr_time) mtime <= merge_bytes(mtime, req_wdata_i, req_wstrb_i);
    else if (tick)    mtime <= mtime + 64'd1;
  end

  // mtimecmp register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
    else if (wr_cmp) mtimecmp <= merge_bytes(mtimecmp, req_wdata_i, req_wstrb_i);
  end

  // Registered level timer interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_int_o <= 1'b0;
    else     timer_int_o <= (mtime >= mtimecmp);
  end

`ifdef CLINT_MSIP_EN
  assign wr_msip = accept && req_wen_i && sel_msip && req_wstrb_i[0];

  // msip storage and its registered interrupt output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msip_q     <= 1'b0;
      soft_int_o <= 1'b0;
    end else begin
      if (wr_msip) msip_q <= req_wdata_i[0];
      soft_int_o <= msip_q;
    end
  end
`endif

  // Bus handshake FSM with registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= 64'd0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            state       <= ST_RESP;
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= dec_err;
            rsp_rdata_o <= (req_wen_i || dec_err) ? 64'd0 : rd_val;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state       <= ST_IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          req_ready_o <= 1'b1;
          rsp_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: directed bench for clint_timer (PRESCALE=1 instance "a", PRESCALE=4 instance "b").
`timescale 1ns/1ps
module tb_clint_timer;

  localparam logic [63:0] A_MTIMECMP = 64'h0000_0000_0200_4000;
  localparam logic [63:0] A_MTIME    = 64'h0000_0000_0200_BFF8;
  localparam logic [63:0] A_MSIP     = 64'h0000_0000_0200_0000;
  localparam logic [63:0] ALL_ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        valid_a, valid_b;
  logic        wen;
  logic [63:0] addr, wdata;
  logic [7:0]  wstrb;
  logic        rsp_ready;

  logic        a_req_ready, a_rsp_valid, a_err, a_tint;
  logic [63:0] a_rdata;
  logic        b_req_ready, b_rsp_valid, b_err, b_tint;
  logic [63:0] b_rdata;
`ifdef CLINT_MSIP_EN
  logic        a_soft, b_soft;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  clint_timer #(.PRESCALE(1)) u_dut_a (
    .clk(clk), .rst(rst_a),
    .req_valid_i(valid_a), .req_ready_o(a_req_ready), .req_wen_i(wen),
    .req_addr_i(addr), .req_wdata_i(wdata), .req_wstrb_i(wstrb),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(a_rdata), .rsp_err_o(a_err), .timer_int_o(a_tint)
`ifdef CLINT_MSIP_EN
    , .soft_int_o(a_soft)
`endif
  );

  clint_timer #(.PRESCALE(4)) u_dut_b (
    .clk(clk), .rst(rst_b),
    .req_valid_i(valid_b), .req_ready_o(b_req_ready), .req_wen_i(wen),
    .req_addr_i(addr), .req_wdata_i(wdata), .req_wstrb_i(wstrb),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(b_rdata), .rsp_err_o(b_err), .timer_int_o(b_tint)
`ifdef CLINT_MSIP_EN
    , .soft_int_o(b_soft)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus transaction; hold > 0 keeps rsp_ready low for that many response cycles.
  task automatic bus_xfer(input bit sel, input logic w, input logic [63:0] a,
                          input logic [63:0] d, input logic [7:0] s, input int hold,
                          output logic [63:0] rd, output logic er);
    int n;
    logic [63:0] first;
    @(negedge clk);
    wen = w; addr = a; wdata = d; wstrb = s; rsp_ready = (hold == 0);
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    check("req_ready_idle", 64'(sel ? b_req_ready : a_req_ready), 64'd1);
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    @(negedge clk);
    check("rsp_latency", 64'(sel ? b_rsp_valid : a_rsp_valid), 64'd1);
    n = 0;
    while (!(sel ? b_rsp_valid : a_rsp_valid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("rsp_timeout", 64'd0, 64'd1);
    first = sel ? b_rdata : a_rdata;
    for (int i = 0; i < hold; i++) begin
      check("hold_rsp_valid", 64'(sel ? b_rsp_valid : a_rsp_valid), 64'd1);
      check("hold_req_ready", 64'(sel ? b_req_ready : a_req_ready), 64'd0);
      check("hold_rdata", sel ? b_rdata : a_rdata, first);
      @(negedge clk);
    end
    rd = sel ? b_rdata : a_rdata;
    er = sel ? b_err : a_err;
    rsp_ready = 1'b1;
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    int          k;

    rst_a = 1'b1; rst_b = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0;
    wen = 1'b0; addr = '0; wdata = '0; wstrb = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_req_ready", 64'(a_req_ready), 64'd1);
    check("rst_rsp_valid", 64'(a_rsp_valid), 64'd0);
    check("rst_rdata", a_rdata, 64'd0);
    check("rst_err", 64'(a_err), 64'd0);
    check("rst_tint", 64'(a_tint), 64'd0);

    // Idle 10 cycles then read mtime
    rst_a = 1'b0;
    repeat (10) @(posedge clk);
    bus_xfer(1'b0, 1'b0, A_MTIME, 64'd0, 8'h00, 0, rd, er);
    check("mtime_after_10", rd, 64'd10);
    check("mtime_rd_err", 64'(er), 64'd0);
    check("tint_idle", 64'(a_tint), 64'd0);

    // mtime=5, mtimecmp=20: interrupt rises one cycle after mtime reaches 20
    bus_xfer(1'b0, 1'b1, A_MTIME, 64'd5, 8'hFF, 0, rd, er);
    check("wr_mtime_rdata", rd, 64'd0);
    bus_xfer(1'b0, 1'b1, A_MTIMECMP, 64'd20, 8'hFF, 0, rd, er);
    check("wr_cmp_err", 64'(er), 64'd0);
    k = 0;
    while (!a_tint && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("tint_rise_cycle", 64'(k), 64'd14);
    bus_xfer(1'b0, 1'b1, A_MTIMECMP, ALL_ONES, 8'hFF, 0, rd, er);
    check("tint_still_high", 64'(a_tint), 64'd1);
    @(negedge clk);
    check("tint_fall", 64'(a_tint), 64'd0);

    // Wrap: mtimecmp=0, mtime=FF..FE
    bus_xfer(1'b0, 1'b1, A_MTIMECMP, 64'd0, 8'hFF, 0, rd, er);
    bus_xfer(1'b0, 1'b1, A_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, rd, er);
    check("wrap_tint0", 64'(a_tint), 64'd1);
    bus_xfer(1'b0, 1'b0, A_MTIME, 64'd0, 8'h00, 0, rd, er);
    check("wrap_pre", rd, ALL_ONES);
    check("wrap_tint1", 64'(a_tint), 64'd1);
    bus_xfer(1'b0, 1'b0, A_MTIME, 64'd0, 8'h00, 0, rd, er);
    check("wrap_post", rd, 64'd1);
    check("wrap_tint2", 64'(a_tint), 64'd1);

    // Zero-strobe write responds cleanly and changes nothing
    bus_xfer(1'b0, 1'b1, A_MTIMECMP, ALL_ONES, 8'h00, 0, rd, er);
    check("wstrb0_err", 64'(er), 64'd0);
    bus_xfer(1'b0, 1'b0, A_MTIMECMP, 64'd0, 8'h00, 0, rd, er);
    check("wstrb0_cmp", rd, 64'd0);

    // Error decode, with a held response
    bus_xfer(1'b0, 1'b0, 64'h0000_0000_0200_1000, 64'd0, 8'h00, 3, rd, er);
    check("unmapped_err", 64'(er), 64'd1);
    check("unmapped_rdata", rd, 64'd0);
    bus_xfer(1'b0, 1'b0, 64'h0000_0000_0200_4004, 64'd0, 8'h00, 0, rd, er);
    check("misalign_err", 64'(er), 64'd1);
    check("misalign_rdata", rd, 64'd0);
    bus_xfer(1'b0, 1'b0, 64'h0000_0000_0300_4000, 64'd0, 8'h00, 0, rd, er);
    check("base_err", 64'(er), 64'd1);
    bus_xfer(1'b0, 1'b1, 64'h0000_0000_0200_4004, 64'h55, 8'hFF, 0, rd, er);
    check("err_wr_err", 64'(er), 64'd1);
    bus_xfer(1'b0, 1'b0, A_MTIMECMP, 64'd0, 8'h00, 0, rd, er);
    check("err_wr_nochange", rd, 64'd0);

    // Byte write to mtime in a tick cycle: increment dropped
    bus_xfer(1'b0, 1'b1, A_MTIME, 64'h1122_3344_5566_0000, 8'hFF, 0, rd, er);
    bus_xfer(1'b0, 1'b1, A_MTIME, 64'h0000_0000_0000_00AA, 8'h01, 0, rd, er);
    bus_xfer(1'b0, 1'b0, A_MTIME, 64'd0, 8'h00, 0, rd, er);
    check("byte_wr_mtime", rd, 64'h1122_3344_5566_00AB);

`ifdef CLINT_MSIP_EN
    bus_xfer(1'b0, 1'b1, A_MSIP, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 0, rd, er);
    check("msip_wr_err", 64'(er), 64'd0);
    check("soft_int_early", 64'(a_soft), 64'd0);
    @(negedge clk);
    check("soft_int_set", 64'(a_soft), 64'd1);
    bus_xfer(1'b0, 1'b0, A_MSIP, 64'd0, 8'h00, 0, rd, er);
    check("msip_rd", rd, 64'd1);
`else
    bus_xfer(1'b0, 1'b0, A_MSIP, 64'd0, 8'h00, 0, rd, er);
    check("msip_absent_err", 64'(er), 64'd1);
`endif

    // PRESCALE=4 instance: 40 cycles after reset mtime is 10
    @(negedge clk);
    rst_b = 1'b0;
    repeat (40) @(posedge clk);
    bus_xfer(1'b1, 1'b0, A_MTIME, 64'd0, 8'h00, 0, rd, er);
    check("ps4_mtime_40", rd, 64'd10);
    bus_xfer(1'b1, 1'b0, A_MTIME, 64'd0, 8'h00, 0, rd, er);
    check("ps4_mtime_42", rd, 64'd10);
    bus_xfer(1'b1, 1'b0, A_MTIME, 64'd0, 8'h00, 0, rd, er);
    check("ps4_mtime_44", rd, 64'd11);
    check("ps4_tint", 64'(b_tint), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
